// File: rtl/ia_pkg.sv
// Shared definitions for the host-interface frame receiver/transmitter pair.
package ia_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int FRAME_LEN      = 61;
  localparam int IDX_W          = 6;

endpackage

// File: rtl/ia_tx_uart_tx_byte.sv
// One-byte UART 8N1 serializer. The start bit is one cycle short because the
// caller's LOAD cycle counts toward it; done strobes in the last stop cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  import ia_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_START = TW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    B_LAST  = 3'(UART_DATA_BITS - 1);

  state_t          state, nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      bitcnt;
  logic [7:0]      shift;

  always_comb begin
    nxt  = state;
    done = 1'b0;
    case (state)
      IDLE:  if (load) nxt = START;
      START: if (timer == T_START) nxt = DATA;
      DATA:  if (timer == T_LAST && bitcnt == B_LAST) nxt = STOP;
      STOP:  if (timer == T_LAST) begin
               nxt  = IDLE;
               done = 1'b1;
             end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx     <= 1'b1;
      timer  <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          timer <= '0;
          if (load) begin
            shift <= data;
            tx    <= 1'b0;
          end
        end
        START:
          if (timer == T_START) begin
            timer  <= '0;
            bitcnt <= '0;
            tx     <= shift[0];
          end else timer <= timer + TW'(1);
        DATA:
          if (timer == T_LAST) begin
            timer  <= '0;
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 3'd1;
            tx     <= (bitcnt == B_LAST) ? 1'b1 : shift[1];
          end else timer <= timer + TW'(1);
        STOP: begin
          tx <= 1'b1;
          if (timer == T_LAST) timer <= '0;
          else                 timer <= timer + TW'(1);
        end
        default: begin
          tx     <= 1'b1;
          timer  <= '0;
          bitcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ia_tx.sv
// Frame transmitter: fetches FRAME_LEN bytes from a latency-1 register-file
// port and sends them back-to-back as UART 8N1, with byte/frame pulses.
module ia_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_LEN    = ia_pkg::FRAME_LEN,
  parameter int IDX_W        = ia_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic             tx,
  output logic             busy,
  output logic             byte_sent,
  output logic             frame_done
);
  import ia_pkg::*;

  state_t state, nxt;
  logic   load, tx_done, last_idx;

  assign last_idx = (rd_idx == IDX_W'(FRAME_LEN - 1));

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .data    (rd_data),
    .tx      (tx),
    .done    (tx_done)
  );

  // DATA here means "byte in flight in the serializer"
  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE:  if (start) nxt = FETCH;
      FETCH: nxt = LOAD;
      LOAD:  begin
               load = 1'b1;
               nxt  = DATA;
             end
      DATA:  if (tx_done) nxt = last_idx ? IDLE : FETCH;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx     <= '0;
      busy       <= 1'b0;
      byte_sent  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      byte_sent  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            rd_idx <= '0;
            busy   <= 1'b1;
          end
        FETCH, LOAD: ;
        DATA:
          if (tx_done) begin
            byte_sent <= 1'b1;
            if (last_idx) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else rd_idx <= rd_idx + IDX_W'(1);
          end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ia_tx.sv
// Bench for ia_tx: cycle-table checks on the first frames, a loopback UART
// receiver feeding a byte scoreboard, and reset/idle corner sequences.
module tb_ia_tx;
  localparam int C   = 4;
  localparam int N   = 3;
  localparam int PER = 1 + 10*C;

  logic       clk = 1'b0;
  logic       reset_n, start, tx, busy, byte_sent, frame_done;
  logic [7:0] rd_data;
  logic [5:0] rd_idx;

  ia_tx #(.CLKS_PER_BIT(C), .FRAME_LEN(N), .IDX_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rd_data    (rd_data),
    .rd_idx     (rd_idx),
    .tx         (tx),
    .busy       (busy),
    .byte_sent  (byte_sent),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int         nchk = 0, nerr = 0;
  int         cyc = 0, acc = -1000, nbs = 0, nfd = 0;
  bit         scramble = 0, rx_discard = 0;
  logic [7:0] mem [N];
  logic [5:0] idx_q = '0;
  logic [7:0] expq [$];
  logic       txp = 1'b1;

  typedef struct {
    int k; bit st; bit tx; bit busy; bit bs; bit fd; int idx;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rdmem(input logic [5:0] a);
    return (int'(a) < N) ? mem[int'(a)] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 register file; in scramble mode only the LOAD cycle carries real data
  always @(negedge clk) begin
    int d;
    d = cyc - acc;
    if (scramble && !(d >= 2 && (d - 2) % PER == 0)) rd_data = 8'($urandom);
    else                                            rd_data = rdmem(idx_q);
    idx_q = rd_idx;
  end

  always @(negedge clk) begin
    if (byte_sent === 1'b1)  nbs++;
    if (frame_done === 1'b1) nfd++;
  end

  // Loopback receiver: start bit is C-1 cycles, then sample mid-bit
  always begin
    logic [7:0] b;
    logic       stp;
    @(negedge clk);
    if (txp === 1'b1 && tx === 1'b0) begin
      repeat (C - 1 + C/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = tx;
        repeat (C) @(negedge clk);
      end
      stp = tx;
      if (rx_discard) rx_discard = 0;
      else begin
        chk("rx_stop", {31'd0, stp}, 1);
        if (expq.size() == 0) chk("rx_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
        else chk("rx_byte", {24'd0, b}, {24'd0, expq.pop_front()});
      end
    end
    txp = tx;
  end

  task automatic push_frame();
    for (int i = 0; i < N; i++) expq.push_back(mem[i]);
  endtask

  task automatic start_frame();
    start = 1'b1;
    acc   = cyc;
    push_frame();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int lim, output int rel);
    rel = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        rel = cyc - 1 - acc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  vi, rel, nbs0, nfd0;
    bit  bdrop, bad;
    tbl = '{
      '{0,0,1,1,0,0,0},   '{1,0,1,1,0,0,0},   '{2,0,0,1,0,0,0},   '{4,0,0,1,0,0,0},
      '{5,0,1,1,0,0,0},   '{8,0,1,1,0,0,0},   '{9,1,0,1,0,0,0},   '{10,0,0,1,0,0,0},
      '{13,0,1,1,0,0,0},  '{17,0,0,1,0,0,0},  '{21,0,0,1,0,0,0},  '{25,0,1,1,0,0,0},
      '{29,0,0,1,0,0,0},  '{33,0,1,1,0,0,0},  '{37,0,1,1,0,0,0},  '{40,0,1,1,0,0,0},
      '{41,0,1,1,1,0,1},  '{42,0,1,1,0,0,1},  '{43,0,0,1,0,0,1},  '{59,1,1,1,0,0,1},
      '{82,0,1,1,1,0,2},  '{83,0,1,1,0,0,2},  '{122,1,1,1,0,0,2}, '{123,1,1,0,1,1,2},
      '{124,0,1,1,0,0,0}, '{125,0,1,1,0,0,0}, '{126,0,0,1,0,0,0}
    };
    mem = '{8'hA5, 8'h3C, 8'hFF};
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_byte_sent", {31'd0, byte_sent}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_rd_idx", {26'd0, rd_idx}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Frame 1 cycle table, with starts while busy, at frame_done, and just after
    start = 1'b1;
    acc   = cyc;
    push_frame();
    vi    = 0;
    bdrop = 0;
    for (int k = 0; k <= 126; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 122 && busy !== 1'b1) bdrop = 1;
      if (vi < tbl.size() && tbl[vi].k == k) begin
        chk($sformatf("k%0d_tx", k), {31'd0, tx}, {31'd0, tbl[vi].tx});
        chk($sformatf("k%0d_busy", k), {31'd0, busy}, {31'd0, tbl[vi].busy});
        chk($sformatf("k%0d_byte_sent", k), {31'd0, byte_sent}, {31'd0, tbl[vi].bs});
        chk($sformatf("k%0d_frame_done", k), {31'd0, frame_done}, {31'd0, tbl[vi].fd});
        chk($sformatf("k%0d_rd_idx", k), {26'd0, rd_idx}, tbl[vi].idx);
        start = tbl[vi].st;
        if (k == 123) begin
          acc      = cyc;
          scramble = 1;
          push_frame();
        end
        vi++;
      end
    end
    chk("busy_continuous", {31'd0, bdrop}, 0);

    // Frame 2 runs with rd_data scrambled outside LOAD
    wait_fd(200, rel);
    chk("f2_frame_done_time", rel, N*PER);
    @(negedge clk);
    scramble = 0;

    // Frame 3: reset during data bit 3 of byte 1 (all-zero byte)
    mem = '{8'h12, 8'h00, 8'h77};
    repeat (2) @(negedge clk);
    start_frame();
    repeat (59) @(negedge clk);
    chk("f3_bit3_low", {31'd0, tx}, 0);
    nbs0 = nbs;
    nfd0 = nfd;
    reset_n    = 1'b0;
    rx_discard = 1;
    expq.delete();
    #1;
    chk("f3_rst_tx", {31'd0, tx}, 1);
    chk("f3_rst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || byte_sent !== 1'b0 || frame_done !== 1'b0) bad = 1;
    end
    chk("f3_idle_after_rst", {31'd0, bad}, 0);
    chk("f3_no_byte_sent", nbs, nbs0);
    chk("f3_no_frame_done", nfd, nfd0);

    // Frame 4: clean frame after the abort
    mem = '{8'hA5, 8'h3C, 8'hFF};
    start_frame();
    wait_fd(200, rel);
    chk("f4_frame_done_time", rel, N*PER);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    chk("byte_sent_total", nbs, 3*N + 1);
    chk("frame_done_total", nfd, 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
